// File: rtl/minterm_pkg.sv
// Shared constants and evaluation helpers for the four-input minterm function.
package minterm_pkg;

  localparam logic [15:0] DEFAULT_TT = 16'h1531;

  // Index is {a,b,c,d} with a as the MSB.
  function automatic logic [3:0] idx4(input logic a, input logic b,
                                      input logic c, input logic d);
    return {a, b, c, d};
  endfunction

  // Sum of products: OR of every true minterm that matches the index.
  function automatic logic eval_sop(input logic [15:0] tt, input logic [3:0] idx);
    logic [4:0] k5;
    logic       r;
    r = 1'b0;
    for (int unsigned k = 0; k < 16; k++) begin
      k5 = 5'(k);
      r  = r | (tt[k5[3:0]] & (idx == k5[3:0]));
    end
    return r;
  endfunction

  // Product of sums: AND over every false entry of (index != entry).
  function automatic logic eval_pos(input logic [15:0] tt, input logic [3:0] idx);
    logic [4:0] k5;
    logic       r;
    r = 1'b1;
    for (int unsigned k = 0; k < 16; k++) begin
      k5 = 5'(k);
      r  = r & (tt[k5[3:0]] | (idx != k5[3:0]));
    end
    return r;
  endfunction

endpackage

// File: rtl/minterm_eval.sv
// Combinational SOP and POS evaluation of a 16-entry truth table.
module minterm_eval
  import minterm_pkg::*;
(
  input  logic [15:0] tt_i,
  input  logic [3:0]  idx_i,
  output logic        sop_o,
  output logic        pos_o
);

  // Two independent forms of the same function so the top can cross-check them.
  always_comb begin
    sop_o = eval_sop(tt_i, idx_i);
    pos_o = eval_pos(tt_i, idx_i);
  end

endmodule

// File: rtl/minterm_sop.sv
// Four-input function evaluator with registered, valid-qualified results,
// SOP/POS consistency flag and saturating hit counter.
module minterm_sop
  import minterm_pkg::*;
#(
  parameter logic [15:0] TRUTH_TABLE = DEFAULT_TT,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  input  logic             d,
  input  logic             in_valid,
  output logic             func_min,
  output logic             func_min_q,
  output logic             func_max_q,
  output logic             out_valid,
  output logic             mismatch,
  output logic [CNT_W-1:0] hit_count
);

  logic [3:0]       idx;
  logic             sop;
  logic             pos;
  logic             func_min_d, func_max_d, out_valid_d, mismatch_d;
  logic             func_min_r, func_max_r, out_valid_r, mismatch_r;
  logic [CNT_W-1:0] hit_count_d, hit_count_r;

  assign idx = idx4(a, b, c, d);

  minterm_eval u_eval (
    .tt_i  (TRUTH_TABLE),
    .idx_i (idx),
    .sop_o (sop),
    .pos_o (pos)
  );

  assign func_min = sop;

  // Next state: capture on valid, hold otherwise; counter saturates at all-ones.
  always_comb begin
    func_min_d  = func_min_r;
    func_max_d  = func_max_r;
    out_valid_d = in_valid;
    mismatch_d  = mismatch_r;
    hit_count_d = hit_count_r;
    if (in_valid) begin
      func_min_d = sop;
      func_max_d = pos;
      if (sop != pos) begin
        mismatch_d = 1'b1;
      end
      if (sop && (hit_count_r != '1)) begin
        hit_count_d = hit_count_r + CNT_W'(1);
      end
    end
  end

  // State registers; reset wins over a coincident valid sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      func_min_r  <= 1'b0;
      func_max_r  <= 1'b0;
      out_valid_r <= 1'b0;
      mismatch_r  <= 1'b0;
      hit_count_r <= '0;
    end else begin
      func_min_r  <= func_min_d;
      func_max_r  <= func_max_d;
      out_valid_r <= out_valid_d;
      mismatch_r  <= mismatch_d;
      hit_count_r <= hit_count_d;
    end
  end

  assign func_min_q = func_min_r;
  assign func_max_q = func_max_r;
  assign out_valid  = out_valid_r;
  assign mismatch   = mismatch_r;
  assign hit_count  = hit_count_r;

endmodule

// File: tb/tb_minterm_sop.sv
// Scoreboard bench for minterm_sop: stimulus pushes expected registered
// results, a negedge monitor pops and compares whenever out_valid is high.
module tb_minterm_sop;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       a = 1'b0, b = 1'b0, c = 1'b0, d = 1'b0;
  logic       in_valid = 1'b0;
  logic       func_min, func_min_q, func_max_q, out_valid, mismatch;
  logic [7:0] hit_count;

  logic       rst2 = 1'b1;
  logic       in_valid2 = 1'b0;
  logic       func_min2, func_min_q2, func_max_q2, out_valid2, mismatch2;
  logic [1:0] hit_count2;

  always #5 clk = ~clk;

  minterm_sop #(.TRUTH_TABLE(16'h1531), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d), .in_valid(in_valid),
    .func_min(func_min), .func_min_q(func_min_q), .func_max_q(func_max_q),
    .out_valid(out_valid), .mismatch(mismatch), .hit_count(hit_count)
  );

  minterm_sop #(.TRUTH_TABLE(16'h1531), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst2), .a(a), .b(b), .c(c), .d(d), .in_valid(in_valid2),
    .func_min(func_min2), .func_min_q(func_min_q2), .func_max_q(func_max_q2),
    .out_valid(out_valid2), .mismatch(mismatch2), .hit_count(hit_count2)
  );

  typedef struct {
    logic       fmin;
    logic       fmax;
    logic       mis;
    logic [7:0] hc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   model_hc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // One stimulus cycle; a valid, non-reset sample queues its expected result.
  task automatic drive(input logic [3:0] idx, input logic v, input logic r, input logic f_exp);
    @(negedge clk);
    {a, b, c, d} = idx;
    in_valid     = v;
    rst          = r;
    if (v && !r) begin
      if (f_exp) model_hc++;
      sb.push_back('{fmin: f_exp, fmax: f_exp, mis: 1'b0, hc: 8'(model_hc)});
    end
  endtask

  task automatic do_reset();
    drive(4'd0, 1'b0, 1'b1, 1'b0);
    drive(4'd0, 1'b0, 1'b1, 1'b0);
    model_hc = 0;
    @(negedge clk);
    chk("rst_func_min_q", func_min_q, 1'b0);
    chk("rst_func_max_q", func_max_q, 1'b0);
    chk("rst_out_valid",  out_valid,  1'b0);
    chk("rst_mismatch",   mismatch,   1'b0);
    chk("rst_hit_count",  hit_count,  8'd0);
  endtask

  // Monitor: compare each presented registered output against the queue head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_unexpected: got out_valid=1 required no output");
        end else begin
          e = sb.pop_front();
          chk("sb_func_min_q", func_min_q, e.fmin);
          chk("sb_func_max_q", func_max_q, e.fmax);
          chk("sb_mismatch",   mismatch,   e.mis);
          chk("sb_hit_count",  hit_count,  e.hc);
        end
      end
    end
  end

  logic [3:0] comb_idx [19] = '{4'd1, 4'd0, 4'd11, 4'd4, 4'd2, 4'd5, 4'd3, 4'd8, 4'd6, 4'd10,
                                4'd7, 4'd12, 4'd9, 4'd5, 4'd13, 4'd8, 4'd14, 4'd10, 4'd15};
  logic       comb_exp [19] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0};
  // Hand truth table for indices 0..15 (true at 0,4,5,8,10,12).
  logic       sweep_exp [16] = '{1, 0, 0, 0, 1, 1, 0, 0, 1, 0, 1, 0, 1, 0, 0, 0};
  logic [1:0] sat_exp [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

  initial begin
    // Combinational sweep, no clock alignment needed.
    for (int i = 0; i < 19; i++) begin
      {a, b, c, d} = comb_idx[i];
      #1;
      chk($sformatf("comb_idx%0d", comb_idx[i]), func_min, comb_exp[i]);
      #4;
    end

    // Registered path: index 4 then index 9.
    do_reset();
    drive(4'd4, 1'b1, 1'b0, 1'b1);
    drive(4'd9, 1'b1, 1'b0, 1'b0);
    drive(4'd0, 1'b0, 1'b0, 1'b0);

    // Valid gating: idle sample must not disturb held results.
    do_reset();
    drive(4'd0, 1'b1, 1'b0, 1'b1);
    drive(4'd1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("gate_func_min_q", func_min_q, 1'b1);
    chk("gate_out_valid",  out_valid,  1'b0);
    chk("gate_hit_count",  hit_count,  8'd1);

    // Full index sweep: six true indices.
    do_reset();
    for (int i = 0; i < 16; i++) drive(4'(i), 1'b1, 1'b0, sweep_exp[i]);
    drive(4'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("sweep_hit_count", hit_count, 8'd6);
    chk("sweep_mismatch",  mismatch,  1'b0);

    // Reset priority over a coincident valid sample.
    drive(4'd0, 1'b1, 1'b0, 1'b1);
    drive(4'd0, 1'b1, 1'b1, 1'b0);
    model_hc = 0;
    drive(4'd0, 1'b0, 1'b0, 1'b0);
    chk("rprio_func_min_q", func_min_q, 1'b0);
    chk("rprio_func_max_q", func_max_q, 1'b0);
    chk("rprio_out_valid",  out_valid,  1'b0);
    chk("rprio_hit_count",  hit_count,  8'd0);
    drive(4'd0, 1'b1, 1'b0, 1'b1);
    drive(4'd0, 1'b0, 1'b0, 1'b0);

    // Saturation on the 2-bit counter instance.
    @(negedge clk);
    rst2 = 1'b0;
    in_valid2 = 1'b1;
    {a, b, c, d} = 4'd12;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("sat_hit_count_%0d", i), hit_count2, sat_exp[i]);
    end
    in_valid2 = 1'b0;
    chk("sat_mismatch", mismatch2, 1'b0);

    @(negedge clk);
    @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/minterm_sop.md
Name: minterm_sop

Overview:
- Four-input Boolean function evaluator, F(a,b,c,d) = Σm(0,4,5,8,10,12), with a as MSB of index {a,b,c,d}.
- Provides a combinational output plus a registered, valid-qualified copy.
- Cross-checks the sum-of-products result against an independent product-of-sums evaluation.
- Keeps a saturating count of true results; used as a small logic-function leaf inside control/decode paths.

Parameters:
- TRUTH_TABLE, 16'h1531, bit i = F for index i={a,b,c,d}; default encodes minterms 0,4,5,8,10,12.
- CNT_W, 8, width of hit counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- a  in  1  function input, index bit 3 (MSB).
- b  in  1  index bit 2.
- c  in  1  index bit 1.
- d  in  1  index bit 0 (LSB).
- in_valid  in  1  qualifies a,b,c,d for registered path.
- func_min  out  1  combinational F = TRUTH_TABLE[{a,b,c,d}], independent of clk/rst/in_valid.
- func_min_q  out  1  registered SOP result.
- func_max_q  out  1  registered POS result: AND over all zero-entries k of TRUTH_TABLE of (index != k).
- out_valid  out  1  registered in_valid.
- mismatch  out  1  registered (SOP != POS) for a valid sample; sticky until reset.
- hit_count  out  CNT_W  number of valid samples with F=1, saturating.

Behaviour:
- Default function, minimal SOP: c'd' + a'bc' + ab'd'.
- Default true indices: 0,4,5,8,10,12.
- Default false indices: 1,2,3,6,7,9,11,13,14,15.
- func_min is purely combinational; it settles within the same delta as the inputs and ignores in_valid.
- Registered path has 1-cycle latency.
- On the rising edge with in_valid=1: func_min_q<=SOP, func_max_q<=POS, out_valid<=1.
- On the rising edge with in_valid=0: out_valid<=0; func_min_q and func_max_q hold their previous values.
- mismatch is set when a valid sample gives SOP!=POS.
  - Sticky until rst.
  - Never set for a correct implementation; it is a self-check for a parameter or encoding error.
- hit_count increments by 1 on each valid sample with F=1.
  - Saturates at 2^CNT_W-1 (no wrap).
  - Holds when in_valid=0 or F=0.
- Reset (sync, rst=1 at the edge) clears func_min_q, func_max_q, out_valid, mismatch and hit_count to 0.
- Reset has priority over in_valid in the same cycle; that sample is discarded.
- Reset mid-stream: the first valid output appears 1 cycle after the first in_valid sampled with rst=0.
- X on any input makes the outputs don't-care.
- No internal state other than the registered outputs and the counter.

Decomposition:
- Package minterm_pkg holds:
  - constant DEFAULT_TT = 16'h1531.
  - function idx4(a,b,c,d) returning a 4-bit index.
  - function eval_sop(tt, idx) and eval_pos(tt, idx).
- One natural sub-module: minterm_eval.
  - Combinational; inputs idx and TT.
  - Outputs sop and pos.
  - Instantiated once; top adds the valid register, mismatch flag and counter.

Test Plan:
- Exhaustive combinational check: apply indices 1,0,11,4,2,5,3,8,6,10,7,12,9,5,13,8,14,10,15 at 5-time-unit spacing.
  - Required func_min: 0,1,0,1,0,1,0,1,0,1,0,1,0,1,0,1,0,1,0.
- Registered path: rst for 2 cycles, then in_valid=1 with index 4.
  - Next edge: func_min_q=1, func_max_q=1, out_valid=1, mismatch=0.
  - Then index 9 gives func_min_q=0 one cycle later.
- Valid gating: send index 0 with in_valid=1, then in_valid=0 with index 1.
  - func_min_q holds 1, out_valid=0, hit_count stays 1.
- Counter: reset, then 16 valid cycles sweeping indices 0..15 → hit_count=6, mismatch=0.
- Saturation: CNT_W=2, then 5 valid samples at index 12 → hit_count=3.
- Reset priority: rst=1 and in_valid=1 with index 0 on the same edge → all registered outputs 0, hit_count=0.
  - rst=0 next cycle → normal operation.
